// File: rtl/serial_deserializer_32bit_pkg.sv
// Shared types and constants for the serial deserializer.
// Holds the word width default, bit counter width and buffer state enum.
package serial_deserializer_32bit_pkg;

    localparam int WORD_W  = 32;
    localparam int COUNT_W = 6;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/serial_deserializer_32bit_word_buffer_1entry.sv
// One-entry valid/ready output buffer with sticky overrun flag.
// Ports: clk, reset (sync, active-low), load_word/load from the collector,
// word_ready from downstream; word_out, word_valid, overrun toward downstream.
module word_buffer_1entry
    import serial_deserializer_32bit_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_word,
    input  logic             load,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);

    buf_state_t       state;
    buf_state_t       next_state;
    logic             take;
    logic             drop;
    logic [WIDTH-1:0] data;
    logic             ovr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BUF_EMPTY;
            data  <= '0;
            ovr   <= 1'b0;
        end else begin
            state <= next_state;
            if (take) data <= load_word;
            if (drop) ovr  <= 1'b1;
        end
    end

    // A drain and a completion on the same edge reload without
    // ever passing through EMPTY, so no word is lost.
    always_comb begin
        next_state = state;
        take       = 1'b0;
        drop       = 1'b0;
        unique case (state)
            BUF_EMPTY: begin
                if (load) begin
                    next_state = BUF_FULL;
                    take       = 1'b1;
                end
            end
            BUF_FULL: begin
                if (word_ready) begin
                    if (load) take = 1'b1;
                    else next_state = BUF_EMPTY;
                end else if (load) begin
                    drop = 1'b1;
                end
            end
            default: next_state = BUF_EMPTY;
        endcase
    end

    assign word_out   = data;
    assign word_valid = (state == BUF_FULL);
    assign overrun    = ovr;

endmodule

// File: rtl/serial_deserializer_32bit.sv
// Bit-serial to word deserializer feeding a one-entry output buffer.
// Ports: clk, reset (sync, active-low), sin/sin_valid in, word_out/word_valid
// with word_ready handshake, bit_count of the partial word, sticky overrun.
module serial_deserializer_32bit
    import serial_deserializer_32bit_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sin,
    input  logic               sin_valid,
    output logic [WIDTH-1:0]   word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [COUNT_W-1:0] bit_count,
    output logic               overrun
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shifted;
    logic [COUNT_W-1:0] count;
    logic               complete;

    // The completed word includes the bit arriving on this edge,
    // so the buffer loads from the shifted value, not from shreg.
    always_comb begin
        shifted = shreg;
        if (LSB_FIRST) shifted = {sin, shreg[WIDTH-1:1]};
        else shifted = {shreg[WIDTH-2:0], sin};
    end

    assign complete = sin_valid && (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg <= '0;
            count <= '0;
        end else if (sin_valid) begin
            shreg <= shifted;
            count <= complete ? '0 : count + COUNT_W'(1);
        end
    end

    word_buffer_1entry #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .load_word (shifted),
        .load      (complete),
        .word_ready(word_ready),
        .word_out  (word_out),
        .word_valid(word_valid),
        .overrun   (overrun)
    );

    assign bit_count = count;

endmodule
